// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the 5-stage datapath and the stall/flush scheduler.
// Defining PIPE_CTRL_PERF_EN adds the stall_cnt_o / flush_cnt_o counter outputs.
interface pipeline_stall_ctrl_if;
    logic        lu_hazard_i;
    logic [1:0]  branch_i;
    logic        dmem_req_i;
    logic        dmem_ready_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        idex_write_o;
    logic        exmem_write_o;
    logic        memwb_write_o;
    logic        ifid_flush_o;
    logic        idex_flush_o;
    logic        exmem_flush_o;
    logic        mem_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        output lu_hazard_i, branch_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        input  ifid_flush_o, idex_flush_o, exmem_flush_o, mem_timeout_o,
        input  stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  lu_hazard_i, branch_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        output ifid_flush_o, idex_flush_o, exmem_flush_o, mem_timeout_o,
        output stall_cnt_o, flush_cnt_o
    );
`else
    modport master (
        output lu_hazard_i, branch_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        input  ifid_flush_o, idex_flush_o, exmem_flush_o, mem_timeout_o
    );
    modport slave (
        input  lu_hazard_i, branch_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
        output ifid_flush_o, idex_flush_o, exmem_flush_o, mem_timeout_o
    );
`endif
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler merging memory freeze, redirect and load-use events.
// Optional PIPE_CTRL_PERF_EN adds saturating stall and redirect counters.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    pipeline_stall_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT - 1);

    state_e     r_state, w_stateNext;
    logic [3:0] r_flushCnt, w_flushCntNext;
    logic [7:0] r_waitCnt, w_waitCntNext;
    logic       r_memTimeout, w_memTimeoutNext;

    logic w_freeze, w_redirect, w_timeoutHit;
    logic w_pcWrite, w_ifidWrite, w_backWrite;
    logic w_ifidFlush, w_idexFlush, w_exmemFlush;

    assign w_freeze     = bus.dmem_req_i & ~bus.dmem_ready_i;
    assign w_redirect   = |bus.branch_i;
    assign w_timeoutHit = (r_waitCnt >= WAIT_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= RUN;
            r_flushCnt   <= 4'd0;
            r_waitCnt    <= 8'd0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_flushCnt   <= w_flushCntNext;
            r_waitCnt    <= w_waitCntNext;
            r_memTimeout <= w_memTimeoutNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_flushCntNext   = r_flushCnt;
        w_waitCntNext    = r_waitCnt;
        w_memTimeoutNext = r_memTimeout;
        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_stateNext   = MEM_WAIT;
                    w_waitCntNext = 8'd1;
                end else if (w_redirect && (FLUSH_CYCLES > 1)) begin
                    w_stateNext    = FLUSH;
                    w_flushCntNext = FLUSH_RELOAD;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready_i) begin
                    w_stateNext   = RUN;
                    w_waitCntNext = 8'd0;
                end else if (w_timeoutHit) begin
                    w_stateNext      = RUN;
                    w_waitCntNext    = 8'd0;
                    w_memTimeoutNext = 1'b1;
                end else if (r_waitCnt != 8'hFF) begin
                    w_waitCntNext = r_waitCnt + 8'd1;
                end
            end
            FLUSH: begin
                // A freeze drops any remaining bubble cycles
                if (w_freeze) begin
                    w_stateNext    = MEM_WAIT;
                    w_waitCntNext  = 8'd1;
                    w_flushCntNext = 4'd0;
                end else if (w_redirect) begin
                    w_flushCntNext = FLUSH_RELOAD;
                end else if (r_flushCnt <= 4'd1) begin
                    w_stateNext    = RUN;
                    w_flushCntNext = 4'd0;
                end else begin
                    w_flushCntNext = r_flushCnt - 4'd1;
                end
            end
            default: begin
                w_stateNext    = RUN;
                w_flushCntNext = 4'd0;
                w_waitCntNext  = 8'd0;
            end
        endcase
    end

    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifidWrite  = 1'b1;
        w_backWrite  = 1'b1;
        w_ifidFlush  = 1'b0;
        w_idexFlush  = 1'b0;
        w_exmemFlush = 1'b0;
        if (rst_i) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_backWrite = 1'b0;
        end else begin
            case (r_state)
                RUN, FLUSH: begin
                    if (w_freeze) begin
                        w_pcWrite   = 1'b0;
                        w_ifidWrite = 1'b0;
                        w_backWrite = 1'b0;
                    end else if (w_redirect) begin
                        w_ifidFlush  = 1'b1;
                        w_idexFlush  = 1'b1;
                        w_exmemFlush = 1'b1;
                    end else if (r_state == FLUSH) begin
                        w_ifidFlush = 1'b1;
                    end else if (bus.lu_hazard_i) begin
                        w_pcWrite   = 1'b0;
                        w_ifidWrite = 1'b0;
                        w_idexFlush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!(bus.dmem_ready_i || w_timeoutHit)) begin
                        w_pcWrite   = 1'b0;
                        w_ifidWrite = 1'b0;
                        w_backWrite = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write_o    = w_pcWrite;
    assign bus.ifid_write_o  = w_ifidWrite;
    assign bus.idex_write_o  = w_backWrite;
    assign bus.exmem_write_o = w_backWrite;
    assign bus.memwb_write_o = w_backWrite;
    assign bus.ifid_flush_o  = w_ifidFlush;
    assign bus.idex_flush_o  = w_idexFlush;
    assign bus.exmem_flush_o = w_exmemFlush;
    assign bus.mem_timeout_o = r_memTimeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stallCnt, r_redirCnt;

    // A redirect event is exactly a cycle with the 3-stage flush asserted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stallCnt <= 32'd0;
            r_redirCnt <= 32'd0;
        end else begin
            if (!w_pcWrite && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_exmemFlush && (r_redirCnt != 32'hFFFF_FFFF)) begin
                r_redirCnt <= r_redirCnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt_o = r_stallCnt;
    assign bus.flush_cnt_o = r_redirCnt;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios plus random traffic
// checked against an event-level reference model.
module tb_pipeline_stall_ctrl;
    localparam int FLUSH_CYCLES = 3;
    localparam int MEM_TIMEOUT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Reference model: how long memory has been frozen, bubbles still owed, error flag
    int       mWaitAge;
    int       mFlushLeft;
    logic     mTimeout;
    longint   mStalls;
    longint   mRedirects;

    logic [8:0] expQ[$];
    int         cycQ[$];
    int         cyc;
    int         nTotal;
    int         nBad;

    task automatic modelReset();
        mWaitAge   = 0;
        mFlushLeft = 0;
        mTimeout   = 1'b0;
        mStalls    = 0;
        mRedirects = 0;
    endtask

    // Returns {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush, exmemFlush, timeout}
    function automatic logic [8:0] modelStep(input logic lu, input logic [1:0] br,
                                             input logic req, input logic rdy);
        logic pc, ifid, back, fIfid, fIdex, fExmem, tmo;
        pc = 1'b1; ifid = 1'b1; back = 1'b1;
        fIfid = 1'b0; fIdex = 1'b0; fExmem = 1'b0;
        tmo = mTimeout;
        if (mWaitAge > 0) begin
            if (rdy) begin
                mWaitAge = 0;
            end else if (mWaitAge >= MEM_TIMEOUT - 1) begin
                mWaitAge = 0;
                mTimeout = 1'b1;
            end else begin
                pc = 1'b0; ifid = 1'b0; back = 1'b0;
                mWaitAge++;
            end
        end else if (req && !rdy) begin
            pc = 1'b0; ifid = 1'b0; back = 1'b0;
            mWaitAge   = 1;
            mFlushLeft = 0;
        end else if (br != 2'b00) begin
            fIfid = 1'b1; fIdex = 1'b1; fExmem = 1'b1;
            mFlushLeft = FLUSH_CYCLES - 1;
        end else if (mFlushLeft > 0) begin
            fIfid = 1'b1;
            mFlushLeft--;
        end else if (lu) begin
            pc = 1'b0; ifid = 1'b0; fIdex = 1'b1;
        end
        if (!pc) mStalls++;
        if (fExmem) mRedirects++;
        return {pc, ifid, back, back, back, fIfid, fIdex, fExmem, tmo};
    endfunction

    // rstMode: 0 = no reset, 1 = reset held across the next edge, 2 = short pulse between edges
    task automatic applyStimulus(input int rstMode, input logic lu, input logic [1:0] br,
                                 input logic req, input logic rdy);
        logic [8:0] expVal;
        @(posedge clk);
        #1;
        bus.lu_hazard_i  = lu;
        bus.branch_i     = br;
        bus.dmem_req_i   = req;
        bus.dmem_ready_i = rdy;
        if (rstMode == 1) begin
            rst = 1'b1;
            modelReset();
            expVal = 9'b0;
        end else begin
            if (rstMode == 2) begin
                rst = 1'b1;
                modelReset();
                #2;
            end
            rst = 1'b0;
            expVal = modelStep(lu, br, req, rdy);
        end
        expQ.push_back(expVal);
        cycQ.push_back(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic checkOutput();
        logic [8:0] want;
        logic [8:0] got;
        int         c;
        want = expQ.pop_front();
        c    = cycQ.pop_front();
        got  = {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o, bus.exmem_write_o,
                bus.memwb_write_o, bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o,
                bus.mem_timeout_o};
        nTotal++;
        if (got !== want) begin
            nBad++;
            $display("[TB] FAIL outputs cyc=%0d got=%b want=%b", c, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput();
    end

    initial begin
        int r;
        int mode;
        nTotal = 0;
        nBad   = 0;
        cyc    = 0;
        modelReset();
        bus.lu_hazard_i  = 1'b0;
        bus.branch_i     = 2'b00;
        bus.dmem_req_i   = 1'b0;
        bus.dmem_ready_i = 1'b0;

        applyStimulus(1, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b11, 1'b1, 1'b0);
        idle(2);

        $display("[TB] load-use stall");
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(2);

        $display("[TB] redirect with bubbles");
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(3);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 1'b0);
        idle(3);

        $display("[TB] memory wait then ready");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b1);
        idle(2);

        $display("[TB] freeze during bubble cycles");
        applyStimulus(0, 1'b0, 2'b11, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b1);
        idle(2);

        $display("[TB] simultaneous freeze, redirect, load-use");
        applyStimulus(0, 1'b1, 2'b10, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 2'b10, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 2'b10, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 1'b0);
        idle(3);

        $display("[TB] memory timeout");
        for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(3);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(1);

        $display("[TB] reset mid memory wait");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(2, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(1);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 99);
            mode = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
            applyStimulus(mode,
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0));
        end
        idle(1);

        @(posedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        nTotal++;
        if (bus.stall_cnt_o !== 32'(mStalls)) begin
            nBad++;
            $display("[TB] FAIL stall_cnt got=%0d want=%0d", bus.stall_cnt_o, mStalls);
        end
        nTotal++;
        if (bus.flush_cnt_o !== 32'(mRedirects)) begin
            nBad++;
            $display("[TB] FAIL flush_cnt got=%0d want=%0d", bus.flush_cnt_o, mRedirects);
        end
`endif
        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
        nTotal++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("[TB] FAIL scoreboard_drain left=%0d want=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
